// File: rtl/piso_pkg.sv
// Shared types, defaults and helpers for the PISO serializer.
// Defining PISO_PARITY_EN adds the PARITY state to piso_state_t.
package piso_pkg;

    localparam int unsigned DefaultW   = 8;
    localparam int unsigned DefaultDiv = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
`ifdef PISO_PARITY_EN
        StShift  = 2'd1,
        StParity = 2'd2
`else
        StShift  = 2'd1
`endif
    } piso_state_t;

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-in handshake plus serial-out strobe bundle of the PISO serializer.
interface piso_serializer_if #(
    parameter int unsigned W = piso_pkg::DefaultW
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         sd;
    logic         sd_en;
    logic         frame;
    logic         done;

    modport master (
        output in_data, in_valid,
        input  in_ready, sd, sd_en, frame, done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, sd, sd_en, frame, done
    );
endinterface

// File: rtl/bit_rate_divider.sv
// DIV-cycle counter that strobes tick in the last cycle of each serial bit.
module bit_rate_divider
    import piso_pkg::*;
#(
    parameter int unsigned DIV = DefaultDiv
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);
    localparam int unsigned CntW = cnt_width(DIV);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = run && (cnt_q == CntW'(DIV - 1));
        cnt_d = cnt_q;
        if (!run || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter, MSB first, DIV clocks per bit with a capture strobe.
// Defining PISO_PARITY_EN appends an even-parity bit after each word.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned W   = DefaultW,
    parameter int unsigned DIV = DefaultDiv
) (
    input logic              clk,
    input logic              reset,
    piso_serializer_if.slave bus
);
    localparam int unsigned BitW = cnt_width(W + 1);

    piso_state_t     state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [BitW-1:0] bit_q, bit_d;
    logic            done_q, done_d;
    logic            tick;
    logic            accept;
`ifdef PISO_PARITY_EN
    logic            parity_q, parity_d;
`endif

    bit_rate_divider #(
        .DIV (DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .run   (state_q != StIdle),
        .tick  (tick)
    );

    always_comb begin
        bus.in_ready = (state_q == StIdle) && !reset;
        bus.frame    = (state_q != StIdle);
        bus.sd_en    = tick;
        bus.done     = done_q;
        bus.sd       = 1'b0;
        if (state_q == StShift) begin
            bus.sd = shift_q[W-1];
        end
`ifdef PISO_PARITY_EN
        if (state_q == StParity) begin
            bus.sd = parity_q;
        end
`endif
    end

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        done_d   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StShift;
                    shift_d  = bus.in_data;
                    bit_d    = '0;
`ifdef PISO_PARITY_EN
                    parity_d = ^bus.in_data;
`endif
                end
            end
            StShift: begin
                if (tick) begin
                    shift_d = shift_q << 1;
                    if (bit_q == BitW'(W - 1)) begin
                        bit_d = '0;
`ifdef PISO_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
`ifdef PISO_PARITY_EN
            StParity: begin
                if (tick) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            bit_q    <= '0;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            done_q   <= done_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: DIV=4 and DIV=1 instances, word capture on sd_en, reset abort,
// busy-time input changes. Follows PISO_PARITY_EN when it is defined.
module tb_piso_serializer;
    import piso_pkg::*;

`ifdef PISO_PARITY_EN
    localparam bit Par = 1'b1;
`else
    localparam bit Par = 1'b0;
`endif
    localparam int NB = Par ? 9 : 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    piso_serializer_if #(.W(8)) a_if ();
    piso_serializer_if #(.W(8)) b_if ();

    piso_serializer #(.W(8), .DIV(4)) u_dut_a (.clk(clk), .reset(reset), .bus(a_if));
    piso_serializer #(.W(8), .DIV(1)) u_dut_b (.clk(clk), .reset(reset), .bus(b_if));

    // Monitor mux so one watcher serves both instances.
    logic sel_b = 1'b0;
    logic m_sd, m_sd_en, m_frame, m_done, m_ready;
    assign m_sd    = sel_b ? b_if.sd       : a_if.sd;
    assign m_sd_en = sel_b ? b_if.sd_en    : a_if.sd_en;
    assign m_frame = sel_b ? b_if.frame    : a_if.frame;
    assign m_done  = sel_b ? b_if.done     : a_if.done;
    assign m_ready = sel_b ? b_if.in_ready : a_if.in_ready;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic logic [8:0] exp_bits(input logic [7:0] d, input logic p);
        return Par ? {d, p} : {1'b0, d};
    endfunction

    task automatic set_in(input logic use_b, input logic v, input logic [7:0] d);
        if (use_b) begin
            b_if.in_valid = v;
            b_if.in_data  = d;
        end else begin
            a_if.in_valid = v;
            a_if.in_data  = d;
        end
    endtask

    // Presents a word in cycle 0 and returns just after its accept edge.
    task automatic accept_word(input string tag, input logic use_b, input logic [7:0] d);
        sel_b = use_b;
        set_in(use_b, 1'b1, d);
        @(negedge clk);
        check({tag, "_ready_c0"}, int'(m_ready), 1);
        @(posedge clk);
        #1;
    endtask

    // Observes cycles 1.. after an accept until done, bounded at 60 cycles.
    task automatic watch(output logic [8:0] bits, output int n, output int first_en,
                         output int last_en, output int done_at, output logic ok);
        bits = '0; n = 0; first_en = -1; last_en = -1; done_at = -1; ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (m_done) begin
                done_at = c;
                if (m_frame || m_sd_en || m_sd || !m_ready) ok = 1'b0;
                break;
            end
            if (!m_frame) ok = 1'b0;
            if (m_sd_en) begin
                bits = {bits[7:0], m_sd};
                n++;
                if (first_en < 0) first_en = c;
                last_en = c;
            end
        end
    endtask

    task automatic check_word(input string tag, input logic [8:0] exp, input int period);
        logic [8:0] bits;
        int n, f, l, d;
        logic ok;
        watch(bits, n, f, l, d, ok);
        check({tag, "_bits"}, int'(bits), int'(exp));
        check({tag, "_nstrobe"}, n, NB);
        check({tag, "_first_en"}, f, period);
        check({tag, "_last_en"}, l, period * NB);
        check({tag, "_done_at"}, d, period * NB + 1);
        check({tag, "_frame_idle"}, int'(ok), 1);
    endtask

    initial begin
        int evts;
        set_in(1'b0, 1'b0, 8'h00);
        set_in(1'b1, 1'b0, 8'h00);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(a_if.in_ready), 0);
        check("rst_frame", int'(a_if.frame), 0);
        check("rst_sd", int'(a_if.sd), 0);
        check("rst_sd_en", int'(a_if.sd_en), 0);
        check("rst_done", int'(a_if.done), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", int'(a_if.in_ready), 1);
        @(posedge clk);
        #1;

        // DIV=4 words.
        accept_word("a5", 1'b0, 8'hA5);
        set_in(1'b0, 1'b0, 8'h00);
        check_word("a5", exp_bits(8'hA5, 1'b0), 4);
        @(posedge clk);
        #1;
        accept_word("07", 1'b0, 8'h07);
        set_in(1'b0, 1'b0, 8'h00);
        check_word("07", exp_bits(8'h07, 1'b1), 4);

        // Input changed while busy; the new word goes in on the done cycle.
        @(posedge clk);
        #1;
        accept_word("5a", 1'b0, 8'h5A);
        set_in(1'b0, 1'b1, 8'h00);
        check_word("5a", exp_bits(8'h5A, 1'b0), 4);
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 8'h00);
        check_word("zero", exp_bits(8'h00, 1'b0), 4);

        // DIV=1, back-to-back words with valid held.
        @(posedge clk);
        #1;
        accept_word("3c", 1'b1, 8'h3C);
        set_in(1'b1, 1'b1, 8'hC3);
        check_word("3c", exp_bits(8'h3C, 1'b0), 1);
        @(posedge clk);
        #1;
        set_in(1'b1, 1'b0, 8'h00);
        check_word("c3", exp_bits(8'hC3, 1'b0), 1);

        // Reset mid-frame aborts the word.
        @(posedge clk);
        #1;
        accept_word("ff", 1'b0, 8'hFF);
        set_in(1'b0, 1'b0, 8'h00);
        repeat (10) @(negedge clk);
        check("ff_frame_c10", int'(a_if.frame), 1);
        reset = 1'b1;
        #1;
        check("ff_ready_in_rst", int'(a_if.in_ready), 0);
        @(negedge clk);
        check("ff_sd_after_rst", int'(a_if.sd), 0);
        check("ff_frame_after_rst", int'(a_if.frame), 0);
        check("ff_sd_en_after_rst", int'(a_if.sd_en), 0);
        check("ff_ready_rst_high", int'(a_if.in_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("ff_ready_released", int'(a_if.in_ready), 1);
        evts = 0;
        for (int c = 0; c < 12; c++) begin
            if (a_if.done || a_if.sd_en || a_if.frame || a_if.sd) evts++;
            @(negedge clk);
        end
        check("ff_no_activity", evts, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter W, default 8: parallel word width; legal range 2..32.
REQ-002 SHALL have parameter DIV, default 4: clock cycles per serial bit; legal range 1..256.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, W bits: parallel word to transmit.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: a word can be accepted this cycle.
REQ-008 SHALL have port sd, output, 1 bit: serial data, MSB first.
REQ-009 SHALL have port sd_en, output, 1 bit: one-cycle capture strobe for the current sd bit, driving downstream enabled flops.
REQ-010 SHALL have port frame, output, 1 bit: high while a word is being shifted.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the last strobe of a word.

Function
REQ-012 SHALL treat a cycle with in_valid=1 and in_ready=1 as the accept cycle; in_data is registered on that edge.
REQ-013 SHALL drive in_ready = (state==IDLE) and not reset; the sender holds in_valid and in_data until acceptance.
REQ-014 SHALL implement the states IDLE, SHIFT and PARITY; PARITY exists only under PISO_PARITY_EN.
REQ-015 SHALL transition IDLE->SHIFT on accept, with bit index 0 and divider count 0.
REQ-016 SHALL hold each bit on sd for exactly DIV cycles and assert sd_en only in the last of those cycles (divider count == DIV-1).
REQ-017 SHALL place the first sd_en DIV cycles after the accept edge; with DIV=1, sd_en is high in every SHIFT cycle.
REQ-018 SHALL leave SHIFT after the strobe of bit W-1: to PARITY if enabled, otherwise to IDLE with done=1 in the first IDLE cycle.
REQ-019 SHALL allow in_ready during the done cycle, so a new word can be accepted in that cycle; the back-to-back gap is 1 cycle.
REQ-020 SHALL drive frame=1 in SHIFT and PARITY, and 0 in IDLE.
REQ-021 SHALL hold sd at 0 in IDLE.
REQ-022 SHALL ignore in_valid while busy, with no effect on the shift register.
REQ-023 SHALL use a divider counter of width clog2(DIV) (minimum 1) and a bit counter of width clog2(W+1); both wrap to 0 at each bit or word boundary.

Reset
REQ-024 SHALL, with reset high, force on the next edge: state IDLE, counters 0, shift register 0, sd=0, sd_en=0, frame=0, done=0; in_ready=0 while reset is high.
REQ-025 SHALL, on reset asserted mid-frame, abort the word with no done and no further sd_en; in_ready=1 in the first cycle after reset is released.

Configuration
REQ-026 SHALL, when macro PISO_PARITY_EN is defined, append one even-parity bit (XOR of the W data bits) after bit W-1, held for DIV cycles with its own sd_en; done then follows the parity strobe.
REQ-027 SHALL, without PISO_PARITY_EN, have no PARITY state and no parity logic; each word is exactly W*DIV SHIFT cycles.

Structure
REQ-028 SHALL take the state enum type (piso_state_t) and the default W/DIV localparams from the shared package piso_pkg.
REQ-029 SHALL instantiate one sub-module, bit_rate_divider (DIV-cycle counter with terminal-count strobe), which generates sd_en timing.

Verification
REQ-030 SHALL cover: W=8, DIV=4, in_data=0xA5 accepted at cycle 0 -> sd bits 1,0,1,0,0,1,0,1; sd_en at cycles 4,8,...,32; done at 33.
REQ-031 SHALL cover: PISO_PARITY_EN, 0xA5 -> 9th bit 0; 0x07 -> 9th bit 1; done at cycle 37 (DIV=4).
REQ-032 SHALL cover: DIV=1, words 0x3C and 0xC3 with continuous in_valid -> sd_en high for 8 cycles, 1-cycle gap, then the second word; the downstream capture equals the inputs.
REQ-033 SHALL cover: reset pulsed at cycle 10 of a 0xFF frame -> sd=0, frame=0, no done, and in_ready=1 one cycle after reset falls.
REQ-034 SHALL cover: in_data changed to 0x00 while busy with in_valid=1 -> the current word is unaffected, and 0x00 is accepted in the done cycle.
